// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared encodings and insert-bit helper for the LED pattern shifter
package led_pattern_pkg;

    localparam logic [1:0] MODE_JOHNSON = 2'b00;
    localparam logic [1:0] MODE_RING    = 2'b01;
    localparam logic [1:0] MODE_SERIAL  = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    localparam logic DIR_TO_MSB = 1'b0;
    localparam logic DIR_TO_LSB = 1'b1;

    // Bit shifted into the vacated end of the register for a given mode.
    function automatic logic insert_bit(input logic [1:0] mode, input logic outgoing,
                                        input logic sin);
        logic b;
        case (mode)
            MODE_JOHNSON: b = ~outgoing;
            MODE_RING:    b = outgoing;
            default:      b = sin;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// rtl/led_step_prescaler.sv - programmable step prescaler producing one tick every div+1 enabled cycles
module led_step_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a runtime decrease of div below cnt recovers at once.
    assign tick = en && (cnt >= div);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_shifter.sv
// rtl/led_pattern_shifter.sv - parametrised LED pattern shift register with feedback modes and status pulses
module led_pattern_shifter
    import led_pattern_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             sin,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             step,
    output logic             wrap
);

    localparam int PH_W = $clog2(2 * WIDTH);

    logic             tick;
    logic             do_shift;
    logic             outgoing;
    logic             new_bit;
    logic [WIDTH-1:0] shifted;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_base;
    logic [PH_W-1:0]  period_last;
    logic [1:0]       prev_mode;

    led_step_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .div   (div),
        .clr   (load),
        .tick  (tick)
    );

    always_comb begin
        outgoing = (dir == DIR_TO_LSB) ? q[0] : q[WIDTH-1];
        new_bit  = insert_bit(mode, outgoing, sin);
        shifted  = (dir == DIR_TO_LSB) ? {new_bit, q[WIDTH-1:1]} : {q[WIDTH-2:0], new_bit};
        do_shift = tick && (mode != MODE_HOLD);
        // A mode change restarts the period; a coincident shift counts as the first step.
        phase_base  = (mode != prev_mode) ? '0 : phase;
        period_last = (mode == MODE_JOHNSON) ? PH_W'(2 * WIDTH - 1) : PH_W'(WIDTH - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q         <= '0;
            phase     <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            prev_mode <= mode;
        end else if (load) begin
            q         <= load_val;
            phase     <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            prev_mode <= mode;
        end else begin
            prev_mode <= mode;
            if (do_shift) begin
                q    <= shifted;
                step <= 1'b1;
                if (phase_base == period_last) begin
                    phase <= '0;
                    wrap  <= 1'b1;
                end else begin
                    phase <= phase_base + PH_W'(1);
                    wrap  <= 1'b0;
                end
            end else begin
                step  <= 1'b0;
                wrap  <= 1'b0;
                phase <= phase_base;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_shifter.sv
// tb/tb_led_pattern_shifter.sv - scoreboard bench for led_pattern_shifter at WIDTH=8
module tb_led_pattern_shifter;

    localparam int WIDTH = 8;
    localparam int DIV_W = 24;

    typedef struct packed {
        logic [7:0] q;
        logic       wrap;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [1:0]       mode;
    logic             dir;
    logic             sin;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             step;
    logic             wrap;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    led_pattern_shifter #(
        .WIDTH(WIDTH),
        .DIV_W(DIV_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div      (div),
        .mode     (mode),
        .dir      (dir),
        .sin      (sin),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .step     (step),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] model_next(input logic [7:0] v, input logic [1:0] m,
                                              input logic d, input logic s);
        logic o, b;
        o = d ? v[0] : v[7];
        b = (m == 2'b00) ? ~o : ((m == 2'b01) ? o : s);
        return d ? {b, v[7:1]} : {v[6:0], b};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int budget, output bit got, output int waited);
        got    = 1'b0;
        waited = 0;
        while (!got && waited < budget) begin
            cycle();
            waited++;
            got = step;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cycle();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle();
        cycle();
        tests++;
        if (q !== 8'h00) begin fails++; $display("FAIL reset_q got=%h want=00", q); end
        tests++;
        if (step !== 1'b0) begin fails++; $display("FAIL reset_step got=%b want=0", step); end
        tests++;
        if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    endtask

    task automatic test_johnson();
        logic [7:0] v;
        exp_t e;
        bit got;
        int waited;
        v = 8'h00;
        for (int i = 1; i <= 16; i++) begin
            v = model_next(v, 2'b00, 1'b0, 1'b0);
            exp_q.push_back('{q: v, wrap: (i == 16)});
        end
        reset = 1'b1;
        while (exp_q.size() > 0) begin
            wait_step(4, got, waited);
            e = exp_q.pop_front();
            tests++;
            if (!got || waited != 1 || q !== e.q || wrap !== e.wrap) begin
                fails++;
                $display("FAIL johnson_seq step=%b waited=%0d q=%h wrap=%b, want step=1 waited=1 q=%h wrap=%b",
                         got, waited, q, wrap, e.q, e.wrap);
            end
        end
    endtask

    task automatic test_ring();
        logic [7:0] tbl [8];
        exp_t e;
        bit got;
        int waited;
        tbl = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        mode = 2'b01;
        dir  = 1'b1;
        div  = '0;
        do_load(8'h81);
        tests++;
        if (q !== 8'h81 || step !== 1'b0) begin
            fails++;
            $display("FAIL ring_load q=%h step=%b, want q=81 step=0", q, step);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back('{q: tbl[i], wrap: (i == 7)});
        while (exp_q.size() > 0) begin
            wait_step(4, got, waited);
            e = exp_q.pop_front();
            tests++;
            if (!got || waited != 1 || q !== e.q || wrap !== e.wrap) begin
                fails++;
                $display("FAIL ring_seq step=%b waited=%0d q=%h wrap=%b, want step=1 waited=1 q=%h wrap=%b",
                         got, waited, q, wrap, e.q, e.wrap);
            end
        end
    endtask

    task automatic test_prescaler();
        exp_t e;
        bit got, any_step;
        int waited;
        int want_wait [6];
        want_wait = '{4, 4, 4, 4, 1, 2};
        mode = 2'b00;
        dir  = 1'b0;
        div  = 24'd3;
        do_load(8'h00);
        exp_q.push_back('{q: 8'h01, wrap: 1'b0});
        exp_q.push_back('{q: 8'h03, wrap: 1'b0});
        exp_q.push_back('{q: 8'h07, wrap: 1'b0});
        exp_q.push_back('{q: 8'h0F, wrap: 1'b0});
        exp_q.push_back('{q: 8'h1F, wrap: 1'b0});
        exp_q.push_back('{q: 8'h3F, wrap: 1'b0});
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                en = 1'b0;
                any_step = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    cycle();
                    any_step |= step;
                end
                tests++;
                if (any_step || q !== 8'h07) begin
                    fails++;
                    $display("FAIL en_freeze step_seen=%b q=%h, want step_seen=0 q=07", any_step, q);
                end
                en = 1'b1;
            end
            if (i == 4) begin
                cycle();
                cycle();
                div = 24'd1;
            end
            wait_step(12, got, waited);
            e = exp_q.pop_front();
            tests++;
            if (!got || waited != want_wait[i] || q !== e.q || wrap !== e.wrap) begin
                fails++;
                $display("FAIL prescale_%0d step=%b waited=%0d q=%h, want step=1 waited=%0d q=%h",
                         i, got, waited, q, want_wait[i], e.q);
            end
        end
    endtask

    task automatic test_serial_hold();
        logic [7:0] tbl [4];
        logic       bits [4];
        exp_t e;
        bit got, any_step;
        int waited;
        tbl  = '{8'h01, 8'h02, 8'h05, 8'h0B};
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        mode = 2'b10;
        dir  = 1'b0;
        div  = '0;
        do_load(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back('{q: tbl[i], wrap: 1'b0});
        for (int i = 0; i < 4; i++) begin
            sin = bits[i];
            wait_step(3, got, waited);
            e = exp_q.pop_front();
            tests++;
            if (!got || waited != 1 || q !== e.q || wrap !== e.wrap) begin
                fails++;
                $display("FAIL serial_%0d step=%b waited=%0d q=%h, want step=1 waited=1 q=%h",
                         i, got, waited, q, e.q);
            end
        end
        mode = 2'b11;
        any_step = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            any_step |= step;
        end
        tests++;
        if (any_step || q !== 8'h0B) begin
            fails++;
            $display("FAIL hold step_seen=%b q=%h, want step_seen=0 q=0B", any_step, q);
        end
    endtask

    task automatic test_load_vs_tick();
        logic [7:0] v;
        exp_t e;
        bit got, any_step;
        int waited;
        mode = 2'b00;
        dir  = 1'b0;
        div  = 24'd2;
        do_load(8'h00);
        any_step = 1'b0;
        cycle();
        any_step |= step;
        cycle();
        any_step |= step;
        do_load(8'h55);
        tests++;
        if (any_step || q !== 8'h55 || step !== 1'b0 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL load_tick step_seen=%b q=%h step=%b wrap=%b, want 0 55 0 0",
                     any_step, q, step, wrap);
        end
        v = 8'h55;
        for (int i = 1; i <= 16; i++) begin
            v = model_next(v, 2'b00, 1'b0, 1'b0);
            exp_q.push_back('{q: v, wrap: (i == 16)});
        end
        while (exp_q.size() > 0) begin
            wait_step(8, got, waited);
            e = exp_q.pop_front();
            tests++;
            if (!got || waited != 3 || q !== e.q || wrap !== e.wrap) begin
                fails++;
                $display("FAIL load_seq step=%b waited=%0d q=%h wrap=%b, want step=1 waited=3 q=%h wrap=%b",
                         got, waited, q, wrap, e.q, e.wrap);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] v;
        exp_t e;
        bit got;
        int waited;
        div = 24'd1;
        do_load(8'h00);
        v = 8'h00;
        for (int i = 0; i < 6; i++) begin
            v = model_next(v, 2'b00, 1'b0, 1'b0);
            exp_q.push_back('{q: v, wrap: 1'b0});
        end
        while (exp_q.size() > 0) begin
            wait_step(6, got, waited);
            e = exp_q.pop_front();
            tests++;
            if (!got || waited != 2 || q !== e.q || wrap !== e.wrap) begin
                fails++;
                $display("FAIL pre_reset_seq step=%b waited=%0d q=%h, want step=1 waited=2 q=%h",
                         got, waited, q, e.q);
            end
        end
        reset = 1'b0;
        cycle();
        tests++;
        if (q !== 8'h00 || step !== 1'b0 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset q=%h step=%b wrap=%b, want 00 0 0", q, step, wrap);
        end
        reset = 1'b1;
        exp_q.push_back('{q: 8'h01, wrap: 1'b0});
        wait_step(6, got, waited);
        e = exp_q.pop_front();
        tests++;
        if (!got || waited != 2 || q !== e.q || wrap !== e.wrap) begin
            fails++;
            $display("FAIL post_reset step=%b waited=%0d q=%h, want step=1 waited=2 q=%h",
                     got, waited, q, e.q);
        end
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b1;
        div      = '0;
        mode     = 2'b00;
        dir      = 1'b0;
        sin      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        test_reset();
        test_johnson();
        test_ring();
        test_prescaler();
        test_serial_hold();
        test_load_vs_tick();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
